// File: rtl/ftq_multi_commit_if.sv
// ftq_multi_commit_if
// Bundles every non-clock signal of the fetch target queue.
//   slave  : seen by the FTQ (BPU P0/P1, IFU ready, flush, commit, query in;
//            full/count, IFU block, redirect, query PC out)
//   master : seen by the environment driving the FTQ (directions reversed)
// Handshake: an IFU transfer occurs in any cycle where ifu_valid_o and
// ifu_ready_i are both high; ifu_valid_o never depends on ifu_ready_i.
// Optional macro: FTQ_COMMIT_CHECK_EN adds commit_error_o.
interface ftq_multi_commit_if #(
  parameter int DEPTH         = 8,
  parameter int ADDR_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int COMMIT_WIDTH  = 2
);
  localparam int IDW = $clog2(DEPTH);
  localparam int CW  = $clog2(COMMIT_WIDTH) + 1;

  logic                     p0_valid_i;
  logic [ADDR_WIDTH-1:0]    p0_pc_i;
  logic [PAYLOAD_WIDTH-1:0] p0_payload_i;
  logic                     p1_valid_i;
  logic [ADDR_WIDTH-1:0]    p1_pc_i;
  logic [PAYLOAD_WIDTH-1:0] p1_payload_i;
  logic                     full_o;
  logic [IDW:0]             count_o;
  logic                     ifu_valid_o;
  logic                     ifu_ready_i;
  logic [ADDR_WIDTH-1:0]    ifu_pc_o;
  logic [PAYLOAD_WIDTH-1:0] ifu_payload_o;
  logic [IDW-1:0]           ifu_id_o;
  logic                     ifu_redirect_o;
  logic                     flush_i;
  logic [IDW-1:0]           flush_id_i;
  logic [CW-1:0]            commit_num_i;
  logic [IDW-1:0]           query_id_i;
  logic [ADDR_WIDTH-1:0]    query_pc_o;
`ifdef FTQ_COMMIT_CHECK_EN
  logic                     commit_error_o;
`endif

  modport slave (
    input  p0_valid_i, p0_pc_i, p0_payload_i,
    input  p1_valid_i, p1_pc_i, p1_payload_i,
    input  ifu_ready_i, flush_i, flush_id_i, commit_num_i, query_id_i,
`ifdef FTQ_COMMIT_CHECK_EN
    output commit_error_o,
`endif
    output full_o, count_o, ifu_valid_o, ifu_pc_o, ifu_payload_o,
    output ifu_id_o, ifu_redirect_o, query_pc_o
  );

  modport master (
    output p0_valid_i, p0_pc_i, p0_payload_i,
    output p1_valid_i, p1_pc_i, p1_payload_i,
    output ifu_ready_i, flush_i, flush_id_i, commit_num_i, query_id_i,
`ifdef FTQ_COMMIT_CHECK_EN
    input  commit_error_o,
`endif
    input  full_o, count_o, ifu_valid_o, ifu_pc_o, ifu_payload_o,
    input  ifu_id_o, ifu_redirect_o, query_pc_o
  );
endinterface

// File: rtl/ftq_multi_commit.sv
// ftq_multi_commit
// Fetch target queue between BPU and IFU. Circular buffer of DEPTH fetch
// blocks (PC + payload) addressed by wrap-bit pointers bpu/ifu/comm.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus.slave  : P0 enqueue, P1 override of last enqueued block, IFU
//                valid/ready issue with redirect, backend flush to a
//                surviving id, multi-block commit, combinational PC query
// Optional macro: FTQ_COMMIT_CHECK_EN clamps commit_num_i to the issued
// count and raises sticky commit_error_o on bad commit/flush requests.
module ftq_multi_commit #(
  parameter int DEPTH         = 8,
  parameter int ADDR_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int COMMIT_WIDTH  = 2
) (
  input logic               clk,
  input logic               rst,
  ftq_multi_commit_if.slave bus
);
  localparam int IDW = $clog2(DEPTH);
  localparam int CW  = $clog2(COMMIT_WIDTH) + 1;

  logic [ADDR_WIDTH-1:0]    r_pc [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] r_pl [DEPTH];
  logic [IDW:0]             r_bpu_ptr, r_ifu_ptr, r_comm_ptr, r_last_ptr;
  logic                     r_last_vld;

  logic               w_full, w_ifu_valid, w_hs, w_enq, w_ovr, w_issued, w_redirect;
  logic [IDW:0]       w_count, w_cnum, w_flush_ptr;
  logic [IDW-1:0]     w_flush_off;

  assign w_full      = (r_bpu_ptr[IDW] != r_comm_ptr[IDW]) &&
                       (r_bpu_ptr[IDW-1:0] == r_comm_ptr[IDW-1:0]);
  assign w_count     = r_bpu_ptr - r_comm_ptr;
  assign w_ifu_valid = (r_ifu_ptr != r_bpu_ptr);
  assign w_hs        = w_ifu_valid & bus.ifu_ready_i;
  assign w_enq       = bus.p0_valid_i & ~w_full & ~bus.p1_valid_i & ~bus.flush_i;
  assign w_ovr       = bus.p1_valid_i & r_last_vld & ~bus.flush_i;
  // The overridden block has reached the IFU if the IFU already moved past
  // it, or is taking it in this very cycle.
  assign w_issued    = (r_ifu_ptr == r_last_ptr + 1'b1) ||
                       (w_hs && (r_ifu_ptr == r_last_ptr));
  assign w_redirect  = w_ovr & w_issued;

  // Flush id only carries the index; rebuild the lap bit relative to comm.
  assign w_flush_off = bus.flush_id_i - r_comm_ptr[IDW-1:0];
  assign w_flush_ptr = r_comm_ptr + {1'b0, w_flush_off};

`ifdef FTQ_COMMIT_CHECK_EN
  logic         r_commit_error;
  logic [IDW:0] w_iss_cnt, w_cnum_raw;
  logic         w_cnum_over, w_flush_bad;

  assign w_iss_cnt   = r_ifu_ptr - r_comm_ptr;
  assign w_cnum_raw  = {{(IDW+1-CW){1'b0}}, bus.commit_num_i};
  assign w_cnum_over = (w_cnum_raw > w_iss_cnt);
  assign w_cnum      = w_cnum_over ? w_iss_cnt : w_cnum_raw;
  assign w_flush_bad = bus.flush_i && ({1'b0, w_flush_off} >= w_count);

  always_ff @(posedge clk) begin
    if (rst) r_commit_error <= 1'b0;
    else if (w_cnum_over || w_flush_bad) r_commit_error <= 1'b1;
  end

  assign bus.commit_error_o = r_commit_error;
`else
  assign w_cnum = {{(IDW+1-CW){1'b0}}, bus.commit_num_i};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bpu_ptr  <= '0;
      r_ifu_ptr  <= '0;
      r_comm_ptr <= '0;
      r_last_ptr <= '0;
      r_last_vld <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i] <= '0;
        r_pl[i] <= '0;
      end
    end else begin
      r_comm_ptr <= r_comm_ptr + w_cnum;
      if (bus.flush_i) begin
        r_bpu_ptr  <= w_flush_ptr + 1'b1;
        r_ifu_ptr  <= w_flush_ptr + 1'b1;
        r_last_vld <= 1'b0;
      end else begin
        if (w_enq) begin
          r_pc[r_bpu_ptr[IDW-1:0]] <= bus.p0_pc_i;
          r_pl[r_bpu_ptr[IDW-1:0]] <= bus.p0_payload_i;
          r_bpu_ptr  <= r_bpu_ptr + 1'b1;
          r_last_ptr <= r_bpu_ptr;
          r_last_vld <= 1'b1;
        end else begin
          r_last_vld <= 1'b0;
        end
        if (w_ovr) begin
          r_pc[r_last_ptr[IDW-1:0]] <= bus.p1_pc_i;
          r_pl[r_last_ptr[IDW-1:0]] <= bus.p1_payload_i;
        end
        if (w_redirect)  r_ifu_ptr <= r_last_ptr;
        else if (w_hs)   r_ifu_ptr <= r_ifu_ptr + 1'b1;
      end
    end
  end

  assign bus.full_o         = w_full;
  assign bus.count_o        = w_count;
  assign bus.ifu_valid_o    = w_ifu_valid;
  assign bus.ifu_pc_o       = r_pc[r_ifu_ptr[IDW-1:0]];
  assign bus.ifu_payload_o  = r_pl[r_ifu_ptr[IDW-1:0]];
  assign bus.ifu_id_o       = r_ifu_ptr[IDW-1:0];
  assign bus.ifu_redirect_o = w_redirect;
  assign bus.query_pc_o     = r_pc[bus.query_id_i];
endmodule

// File: tb/tb_ftq_multi_commit.sv
// tb_ftq_multi_commit
// Directed bench for ftq_multi_commit: reset, fill/full, P1 redirect,
// P1 without redirect, commit with pointer wrap, flush, and (with
// FTQ_COMMIT_CHECK_EN) commit clamping and sticky error.
module tb_ftq_multi_commit;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int PW    = 8;
  localparam int CMW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ftq_multi_commit_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .PAYLOAD_WIDTH(PW),
                        .COMMIT_WIDTH(CMW)) bus ();

  ftq_multi_commit #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .PAYLOAD_WIDTH(PW),
                     .COMMIT_WIDTH(CMW)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic idle();
    bus.p0_valid_i   = 1'b0;
    bus.p0_pc_i      = '0;
    bus.p0_payload_i = '0;
    bus.p1_valid_i   = 1'b0;
    bus.p1_pc_i      = '0;
    bus.p1_payload_i = '0;
    bus.ifu_ready_i  = 1'b0;
    bus.flush_i      = 1'b0;
    bus.flush_id_i   = '0;
    bus.commit_num_i = '0;
    bus.query_id_i   = '0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [PW-1:0] pl);
    bus.p0_valid_i   = 1'b1;
    bus.p0_pc_i      = pc;
    bus.p0_payload_i = pl;
    step();
    bus.p0_valid_i   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", bus.full_o); end
    n_checks++; if (bus.count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
    n_checks++; if (bus.ifu_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ifu_valid got %0b want 0", bus.ifu_valid_o); end
    n_checks++; if (bus.ifu_redirect_o !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got %0b want 0", bus.ifu_redirect_o); end
    n_checks++; if (bus.query_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_query_pc got %h want 0", bus.query_pc_o); end
`ifdef FTQ_COMMIT_CHECK_EN
    n_checks++; if (bus.commit_error_o !== 1'b0) begin n_fail++; $display("FAIL reset_commit_error got %0b want 0", bus.commit_error_o); end
`endif
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(32'h1000 + 32'h10 * i, 8'(i));
      n_checks++; if (bus.count_o !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bus.count_o, i + 1); end
    end
    n_checks++; if (bus.full_o !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b want 1", bus.full_o); end
    push(32'h1080, 8'h88);
    n_checks++; if (bus.count_o !== 4'd8) begin n_fail++; $display("FAIL drop_count got %0d want 8", bus.count_o); end
    bus.query_id_i = 3'd0; #1;
    n_checks++; if (bus.query_pc_o !== 32'h1000) begin n_fail++; $display("FAIL drop_entry0 got %h want 1000", bus.query_pc_o); end
    bus.query_id_i = 3'd7; #1;
    n_checks++; if (bus.query_pc_o !== 32'h1070) begin n_fail++; $display("FAIL query_entry7 got %h want 1070", bus.query_pc_o); end
    bus.commit_num_i = 2'd0;
    step();
    n_checks++; if (bus.full_o !== 1'b1) begin n_fail++; $display("FAIL commit0_full got %0b want 1", bus.full_o); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.ifu_ready_i = 1'b1;
    push(32'h2000, 8'h11);
    n_checks++; if (bus.ifu_valid_o !== 1'b1) begin n_fail++; $display("FAIL rd_valid got %0b want 1", bus.ifu_valid_o); end
    n_checks++; if (bus.ifu_pc_o !== 32'h2000) begin n_fail++; $display("FAIL rd_pc got %h want 2000", bus.ifu_pc_o); end
    n_checks++; if (bus.ifu_id_o !== 3'd0) begin n_fail++; $display("FAIL rd_id got %0d want 0", bus.ifu_id_o); end
    bus.p1_valid_i = 1'b1; bus.p1_pc_i = 32'h2040; bus.p1_payload_i = 8'h22;
    #1;
    n_checks++; if (bus.ifu_redirect_o !== 1'b1) begin n_fail++; $display("FAIL rd_redirect got %0b want 1", bus.ifu_redirect_o); end
    step();
    bus.p1_valid_i = 1'b0; #1;
    n_checks++; if (bus.ifu_valid_o !== 1'b1) begin n_fail++; $display("FAIL rd_resend_valid got %0b want 1", bus.ifu_valid_o); end
    n_checks++; if (bus.ifu_pc_o !== 32'h2040) begin n_fail++; $display("FAIL rd_resend_pc got %h want 2040", bus.ifu_pc_o); end
    n_checks++; if (bus.ifu_payload_o !== 8'h22) begin n_fail++; $display("FAIL rd_resend_payload got %h want 22", bus.ifu_payload_o); end
    n_checks++; if (bus.ifu_id_o !== 3'd0) begin n_fail++; $display("FAIL rd_resend_id got %0d want 0", bus.ifu_id_o); end
    n_checks++; if (bus.ifu_redirect_o !== 1'b0) begin n_fail++; $display("FAIL rd_redirect_clear got %0b want 0", bus.ifu_redirect_o); end
    step();
    n_checks++; if (bus.ifu_valid_o !== 1'b0) begin n_fail++; $display("FAIL rd_drained got %0b want 0", bus.ifu_valid_o); end
  endtask

  task automatic test_no_redirect();
    do_reset();
    push(32'h3000, 8'h33);
    bus.p1_valid_i = 1'b1; bus.p1_pc_i = 32'h3080; bus.p1_payload_i = 8'h44;
    bus.p0_valid_i = 1'b1; bus.p0_pc_i = 32'h3100;
    #1;
    n_checks++; if (bus.ifu_redirect_o !== 1'b0) begin n_fail++; $display("FAIL nr_redirect got %0b want 0", bus.ifu_redirect_o); end
    step();
    idle(); #1;
    n_checks++; if (bus.count_o !== 4'd1) begin n_fail++; $display("FAIL nr_count got %0d want 1", bus.count_o); end
    n_checks++; if (bus.ifu_pc_o !== 32'h3080) begin n_fail++; $display("FAIL nr_pc got %h want 3080", bus.ifu_pc_o); end
    // A late P1 (no block enqueued the cycle before) must be ignored.
    bus.p1_valid_i = 1'b1; bus.p1_pc_i = 32'h3FF0;
    step();
    idle(); #1;
    n_checks++; if (bus.ifu_pc_o !== 32'h3080) begin n_fail++; $display("FAIL nr_late_p1 got %h want 3080", bus.ifu_pc_o); end
  endtask

  task automatic test_commit_wrap();
    logic [AW-1:0] pc;
    int            id;
    do_reset();
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 6; i++) push(32'h4000 + 32'h100 * lap + 32'h4 * i, 8'(i));
      n_checks++; if (bus.count_o !== 4'd6) begin n_fail++; $display("FAIL wrap_count6[%0d] got %0d want 6", lap, bus.count_o); end
      n_checks++; if (bus.full_o !== 1'b0) begin n_fail++; $display("FAIL wrap_full[%0d] got %0b want 0", lap, bus.full_o); end
      bus.ifu_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
        id = (lap * 6 + i) % 8;
        pc = 32'h4000 + 32'h100 * lap + 32'h4 * i;
        n_checks++; if (bus.ifu_id_o !== 3'(id)) begin n_fail++; $display("FAIL wrap_id[%0d.%0d] got %0d want %0d", lap, i, bus.ifu_id_o, id); end
        n_checks++; if (bus.ifu_pc_o !== pc) begin n_fail++; $display("FAIL wrap_pc[%0d.%0d] got %h want %h", lap, i, bus.ifu_pc_o, pc); end
        step();
      end
      bus.ifu_ready_i = 1'b0;
      n_checks++; if (bus.ifu_valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_issued[%0d] got %0b want 0", lap, bus.ifu_valid_o); end
      bus.commit_num_i = 2'd2;
      for (int c = 0; c < 3; c++) begin
        step();
        n_checks++; if (bus.count_o !== 4'(4 - 2 * c)) begin n_fail++; $display("FAIL wrap_commit[%0d.%0d] got %0d want %0d", lap, c, bus.count_o, 4 - 2 * c); end
      end
      bus.commit_num_i = 2'd0;
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 6; i++) push(32'h5000 + 32'h10 * i, 8'(i));
    bus.ifu_ready_i = 1'b1;
    step(); step(); step();
    bus.ifu_ready_i = 1'b0;
    bus.flush_i = 1'b1; bus.flush_id_i = 3'd2; bus.commit_num_i = 2'd1;
    #1;
    n_checks++; if (bus.ifu_redirect_o !== 1'b0) begin n_fail++; $display("FAIL fl_redirect got %0b want 0", bus.ifu_redirect_o); end
    step();
    idle(); #1;
    n_checks++; if (bus.count_o !== 4'd2) begin n_fail++; $display("FAIL fl_count got %0d want 2", bus.count_o); end
    n_checks++; if (bus.ifu_valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_ifu_valid got %0b want 0", bus.ifu_valid_o); end
    push(32'h5555, 8'h55);
    n_checks++; if (bus.ifu_valid_o !== 1'b1) begin n_fail++; $display("FAIL fl_next_valid got %0b want 1", bus.ifu_valid_o); end
    n_checks++; if (bus.ifu_id_o !== 3'd3) begin n_fail++; $display("FAIL fl_next_id got %0d want 3", bus.ifu_id_o); end
    n_checks++; if (bus.ifu_pc_o !== 32'h5555) begin n_fail++; $display("FAIL fl_next_pc got %h want 5555", bus.ifu_pc_o); end
    n_checks++; if (bus.count_o !== 4'd3) begin n_fail++; $display("FAIL fl_next_count got %0d want 3", bus.count_o); end
`ifdef FTQ_COMMIT_CHECK_EN
    n_checks++; if (bus.commit_error_o !== 1'b0) begin n_fail++; $display("FAIL fl_no_error got %0b want 0", bus.commit_error_o); end
`endif
  endtask

`ifdef FTQ_COMMIT_CHECK_EN
  task automatic test_commit_check();
    do_reset();
    push(32'h6000, 8'h60);
    push(32'h6010, 8'h61);
    bus.ifu_ready_i = 1'b1;
    step();
    bus.ifu_ready_i = 1'b0;
    bus.commit_num_i = 2'd2;
    step();
    bus.commit_num_i = 2'd0;
    n_checks++; if (bus.count_o !== 4'd1) begin n_fail++; $display("FAIL cc_clamp_count got %0d want 1", bus.count_o); end
    n_checks++; if (bus.commit_error_o !== 1'b1) begin n_fail++; $display("FAIL cc_error got %0b want 1", bus.commit_error_o); end
    step(); step(); step();
    n_checks++; if (bus.commit_error_o !== 1'b1) begin n_fail++; $display("FAIL cc_sticky got %0b want 1", bus.commit_error_o); end
    do_reset();
    n_checks++; if (bus.commit_error_o !== 1'b0) begin n_fail++; $display("FAIL cc_rst_clear got %0b want 0", bus.commit_error_o); end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_fill();
    test_redirect();
    test_no_redirect();
    test_commit_wrap();
    test_flush();
`ifdef FTQ_COMMIT_CHECK_EN
    test_commit_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
